// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. It decodes the
// instruction format straight from opcode/funct3 and builds the extended
// immediate for all RV32/RV64 formats, including shift amounts and CSR zimm.
// The result is registered behind a valid/ready handshake. With SKID_EN=1
// there is a one-entry skid buffer, so in_ready is a pure register output.
//
// Parameters
//   XLEN     datapath width, 32 or 64
//   SKID_EN  1: out reg + skid reg, in_ready registered
//            0: out reg only, in_ready = out_ready || !out_valid
//               (combinational path from out_ready to in_ready)
//
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous active-high reset (priority over flush)
//   flush        synchronous kill of all held entries; drops a same-cycle accept
//   in_valid     upstream offers in_instr / in_pc
//   in_ready     block can accept this cycle
//   in_instr     raw 32-bit instruction word
//   in_pc        PC of in_instr, carried alongside
//   out_valid    out_* fields valid
//   out_ready    downstream consumes this cycle
//   out_imm      extended immediate
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 Z
//   out_illegal  instr[1:0] != 2'b11 (forces fmt NONE, imm 0)
//   out_pc       PC carried from input
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_Z    = 3'd7;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // Format decode and immediate assembly (combinational, from inputs)
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sgn;
    logic        is_shift;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [63:0] imm_sh64, imm_sh32, imm_z;
    logic [63:0] dec_imm64;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;
    entry_t      dec_entry;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign sgn      = in_instr[31];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate is built 64 bits wide and sign-extended from bit 31;
    // truncating to XLEN afterwards gives the same result for XLEN=32.
    assign imm_i    = {{52{sgn}}, in_instr[31:20]};
    assign imm_s    = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b    = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
    assign imm_u    = {{32{sgn}}, in_instr[31:12], 12'b0};
    assign imm_j    = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
    assign imm_sh64 = {58'b0, in_instr[25:20]};
    assign imm_sh32 = {59'b0, in_instr[24:20]};
    assign imm_z    = {59'b0, in_instr[19:15]};

    assign dec_illegal = (in_instr[1:0] != 2'b11);

    always_comb begin
        dec_fmt   = FMT_NONE;
        dec_imm64 = 64'b0;
        if (!dec_illegal) begin
            case (opcode)
                OPC_OP_IMM: begin
                    if (is_shift) begin
                        dec_fmt   = FMT_SH;
                        // RV64 shifts use a 6-bit shamt, RV32 only 5 bits.
                        dec_imm64 = (XLEN == 64) ? imm_sh64 : imm_sh32;
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm64 = imm_i;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (is_shift) begin
                        dec_fmt   = FMT_SH;
                        dec_imm64 = imm_sh32;
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm64 = imm_i;
                    end
                end
                OPC_LOAD, OPC_JALR: begin
                    dec_fmt   = FMT_I;
                    dec_imm64 = imm_i;
                end
                OPC_STORE: begin
                    dec_fmt   = FMT_S;
                    dec_imm64 = imm_s;
                end
                OPC_BRANCH: begin
                    dec_fmt   = FMT_B;
                    dec_imm64 = imm_b;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt   = FMT_U;
                    dec_imm64 = imm_u;
                end
                OPC_JAL: begin
                    dec_fmt   = FMT_J;
                    dec_imm64 = imm_j;
                end
                OPC_SYSTEM: begin
                    // funct3[2] selects the immediate CSR forms (zimm in rs1).
                    if (funct3[2]) begin
                        dec_fmt   = FMT_Z;
                        dec_imm64 = imm_z;
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm64 = imm_i;
                    end
                end
                default: begin
                    dec_fmt   = FMT_NONE;
                    dec_imm64 = 64'b0;
                end
            endcase
        end
    end

    assign dec_entry.imm     = dec_imm64[XLEN-1:0];
    assign dec_entry.fmt     = dec_fmt;
    assign dec_entry.illegal = dec_illegal;
    assign dec_entry.pc      = in_pc;

    // ------------------------------------------------------------------
    // Output register + optional skid register
    // ------------------------------------------------------------------
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   accept;
    logic   out_free;

    generate
        if (SKID_EN) begin : g_ready_skid
            assign in_ready = !skid_valid_q;
        end else begin : g_ready_comb
            // Combinational out_ready -> in_ready path.
            assign in_ready = out_ready || !out_valid_q;
        end
    endgenerate

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            // Kill everything held; a same-cycle accept is dropped too.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept here.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept && SKID_EN) begin
            // Out reg stalled: park the new result behind it.
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_pc      = out_q.pc;

endmodule
